// File: rtl/winograd_pkg.sv
// winograd_pkg: tile geometry, scheduler state encoding and config validation
package winograd_pkg;

    localparam int TILE    = 6;
    localparam int STRIDE  = 4;
    localparam int OVERLAP = 2;

    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, STORE, NEXT, FIN} state_t;

    // Dimensions must be 4k+2 and >= 6, and every read and write address must fit in aw bits
    function automatic logic cfg_ok(input logic [7:0] rows, input logic [7:0] cols, input int aw);
        logic [63:0] limit;
        logic [63:0] tiles;
        limit = 64'd1 << aw;
        tiles = 64'((rows - 8'd2) >> 2) * 64'((cols - 8'd2) >> 2);
        return rows >= 8'(TILE) && cols >= 8'(TILE)
            && rows[1:0] == 2'(OVERLAP) && cols[1:0] == 2'(OVERLAP)
            && 64'(rows) * 64'(cols) <= limit
            && tiles * 64'(TILE * TILE) <= limit;
    endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: tile (tr, tc) and element (i, j, k) counters with read/write address generation
module tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            cols,
    input  logic [5:0]            tiles_per_row,
    input  logic [5:0]            tile_rows,
    input  logic                  clr_elem,
    input  logic                  step_elem,
    input  logic                  clr_tile,
    input  logic                  step_tile,
    output logic [5:0]            k,
    output logic [2:0]            i,
    output logic [2:0]            j,
    output logic                  last_tile,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    localparam int AW = ADDR_WIDTH;

    logic [5:0]    tr;
    logic [5:0]    tc;
    logic          last_col;
    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [AW-1:0] tile_index;

    assign last_col  = tc == tiles_per_row - 6'd1;
    assign last_tile = last_col && tr == tile_rows - 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k  <= '0;
            i  <= '0;
            j  <= '0;
            tr <= '0;
            tc <= '0;
        end else begin
            if (clr_elem) begin
                k <= '0;
                i <= '0;
                j <= '0;
            end else if (step_elem) begin
                k <= k + 6'd1;
                j <= (j == 3'(TILE - 1)) ? '0 : j + 3'd1;
                if (j == 3'(TILE - 1))
                    i <= (i == 3'(TILE - 1)) ? '0 : i + 3'd1;
            end
            if (clr_tile) begin
                tr <= '0;
                tc <= '0;
            end else if (step_tile) begin
                tc <= last_col ? '0 : tc + 6'd1;
                if (last_col)
                    tr <= tr + 6'd1;
            end
        end
    end

    // Absolute image coordinates of the current element; tiles overlap because STRIDE < TILE
    assign row        = AW'(tr) * AW'(STRIDE) + AW'(i);
    assign col        = AW'(tc) * AW'(STRIDE) + AW'(j);
    assign rd_addr    = row * AW'(cols) + col;
    assign tile_index = AW'(tr) * AW'(tiles_per_row) + AW'(tc);
    assign wr_addr    = tile_index * AW'(TILE * TILE) + AW'(i) * AW'(TILE) + AW'(j);

endmodule

// File: rtl/tile_transform_scheduler.sv
// tile_transform_scheduler: walks overlapping 6x6 tiles of an image through a tile transform unit
module tile_transform_scheduler
    import winograd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [7:0]                                cfg_rows,
    input  logic [7:0]                                cfg_cols,
    output logic                                      rd_en,
    output logic [ADDR_WIDTH-1:0]                     rd_addr,
    input  logic [DATA_WIDTH-1:0]                     rd_data,
    output logic                                      ttu_start,
    output logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] ttu_tile_in,
    input  logic [TILE-1:0][TILE-1:0][DATA_WIDTH-1:0] ttu_tile_out,
    input  logic                                      ttu_done,
    output logic                                      wr_en,
    output logic [ADDR_WIDTH-1:0]                     wr_addr,
    output logic [DATA_WIDTH-1:0]                     wr_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      err
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cols_q;
    logic [5:0] tpr;
    logic [5:0] trows;
    logic [5:0] k;
    logic [2:0] i;
    logic [2:0] j;
    logic [2:0] pi;
    logic [2:0] pj;
    logic       pv;
    logic       err_q;
    logic       last_tile;
    logic       launch;
    logic       bad_cfg;
    logic       clr_elem;
    logic       step_elem;
    logic       clr_tile;
    logic       step_tile;

    assign launch  = state == IDLE && start && !abort;
    assign bad_cfg = !cfg_ok(cfg_rows, cfg_cols, ADDR_WIDTH);

    tile_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk           (clk),
        .rst_n         (rst_n),
        .cols          (cols_q),
        .tiles_per_row (tpr),
        .tile_rows     (trows),
        .clr_elem      (clr_elem),
        .step_elem     (step_elem),
        .clr_tile      (clr_tile),
        .step_tile     (step_tile),
        .k             (k),
        .i             (i),
        .j             (j),
        .last_tile     (last_tile),
        .rd_addr       (rd_addr),
        .wr_addr       (wr_addr)
    );

    // Read data returns one cycle late, so the element index is delayed alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cols_q      <= '0;
            tpr         <= '0;
            trows       <= '0;
            pv          <= 1'b0;
            pi          <= '0;
            pj          <= '0;
            err_q       <= 1'b0;
            ttu_tile_in <= '0;
        end else begin
            state <= state_nx;
            err_q <= launch && bad_cfg;
            pv    <= rd_en;
            pi    <= i;
            pj    <= j;
            if (launch && !bad_cfg) begin
                cols_q <= cfg_cols;
                tpr    <= 6'((cfg_cols - 8'd2) >> 2);
                trows  <= 6'((cfg_rows - 8'd2) >> 2);
            end
            if (pv && state == LOAD)
                ttu_tile_in[pi][pj] <= rd_data;
        end
    end

    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        ttu_start = 1'b0;
        clr_elem  = 1'b0;
        step_elem = 1'b0;
        clr_tile  = 1'b0;
        step_tile = 1'b0;
        case (state)
            IDLE: begin
                clr_elem = 1'b1;
                clr_tile = 1'b1;
                state_nx = (launch && !bad_cfg) ? LOAD : IDLE;
            end
            LOAD: begin
                rd_en     = k < 6'(TILE * TILE);
                step_elem = 1'b1;
                clr_elem  = k == 6'(TILE * TILE);
                state_nx  = clr_elem ? KICK : LOAD;
            end
            KICK: begin
                ttu_start = !ttu_done;
                state_nx  = ttu_done ? KICK : WAIT;
            end
            WAIT:  state_nx = ttu_done ? STORE : WAIT;
            STORE: begin
                wr_en     = 1'b1;
                step_elem = 1'b1;
                clr_elem  = k == 6'(TILE * TILE - 1);
                state_nx  = clr_elem ? NEXT : STORE;
            end
            NEXT: begin
                step_tile = 1'b1;
                state_nx  = last_tile ? FIN : LOAD;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE)
            state_nx = IDLE;
    end

    assign busy    = state != IDLE;
    assign done    = state == FIN && !abort;
    assign err     = err_q;
    assign wr_data = wr_en ? ttu_tile_out[i][j] : '0;

endmodule
